// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product token vending controller.
package vend_pkg;

    // Upper bounds used to size the generic helper arguments.
    localparam int MAX_PRODUCTS = 7;
    localparam int MAX_CW       = 32;
    localparam int PRICES_EXT_W = MAX_PRODUCTS * MAX_CW;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_t;

    // Price of product idx from a packed price vector with cw-bit slices.
    function automatic logic [MAX_CW-1:0] price_slice(
        input logic [PRICES_EXT_W-1:0] prices,
        input int                      cw,
        input int                      idx
    );
        logic [PRICES_EXT_W-1:0] mask;
        mask = (PRICES_EXT_W'(1) << cw) - PRICES_EXT_W'(1);
        return MAX_CW'((prices >> (idx * cw)) & mask);
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [MAX_PRODUCTS-1:0] bits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = MAX_PRODUCTS - 1; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Inactivity counter: asserts expired on the cycle the count reaches TIMEOUT_CYCLES-1.
module vend_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_disabled
        // Timeout refund turned off; inputs deliberately unused.
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, reset_n, clear, enable};
        assign expired   = 1'b0;
    end else begin : g_enabled
        localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
        localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

        logic [CNT_W-1:0] count;

        // Count idle cycles, holding at the terminal value until cleared.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count <= '0;
            end else if (clear) begin
                count <= '0;
            end else if (enable && (count != LAST)) begin
                count <= count + CNT_W'(1);
            end
        end

        assign expired = enable && (count == LAST);
    end

endmodule

// File: rtl/vend_multi.sv
// Multi-product token vending controller with saturating credit, cancel and timeout refund.
module vend_multi
    import vend_pkg::*;
#(
    parameter int                            N_PRODUCTS     = 3,
    parameter int                            CREDIT_W       = 8,
    parameter int                            MAX_CREDIT     = 15,
    parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICES        = {8'd3, 8'd2, 8'd1},
    parameter int                            TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  token_in,
    input  logic [N_PRODUCTS-1:0] button,
    input  logic                  cancel,
    input  logic                  dispense_done,
    output logic                  vend_busy,
    output logic                  dispense,
    output logic [2:0]            product_select,
    output logic [CREDIT_W-1:0]   credit,
    output logic                  change_valid,
    output logic [CREDIT_W-1:0]   change_tokens,
    output logic                  token_reject,
    output logic                  insufficient
);

    localparam logic [PRICES_EXT_W-1:0] PRICES_EXT = PRICES_EXT_W'(PRICES);
    localparam logic [CREDIT_W-1:0]     MAX_C      = CREDIT_W'(MAX_CREDIT);

    // Reject illegal configurations at elaboration time.
    if (N_PRODUCTS < 1 || N_PRODUCTS > MAX_PRODUCTS) begin : g_bad_n
        $error("vend_multi: N_PRODUCTS must be 1..7");
    end
    if (CREDIT_W < 1 || CREDIT_W > MAX_CW) begin : g_bad_w
        $error("vend_multi: CREDIT_W must be 1..32");
    end
    if (MAX_CREDIT < 1 || (CREDIT_W < 32 && (MAX_CREDIT >> CREDIT_W) != 0)) begin : g_bad_max
        $error("vend_multi: MAX_CREDIT must be >= 1 and < 2**CREDIT_W");
    end
    for (genvar g = 0; g < N_PRODUCTS; g++) begin : g_price_chk
        localparam int P = int'(price_slice(PRICES_EXT, CREDIT_W, g));
        if (P == 0 || P > MAX_CREDIT) begin : g_bad_price
            $error("vend_multi: every price must be 1..MAX_CREDIT");
        end
    end

    vend_state_t         state, state_nxt;
    logic [2:0]          sel_idx, sel_nxt;
    logic [CREDIT_W-1:0] credit_nxt, ct_nxt;
    logic [2:0]          ps_nxt;
    logic                disp_nxt, cv_nxt, rej_nxt, ins_nxt, busy_nxt;
    logic                timer_expired, timer_clear, timer_enable;
    logic [2:0]          btn_idx;
    logic [CREDIT_W-1:0] btn_price, sel_price;

    assign btn_idx   = lowest_set(MAX_PRODUCTS'(button));
    assign btn_price = CREDIT_W'(price_slice(PRICES_EXT, CREDIT_W, int'(btn_idx)));
    assign sel_price = CREDIT_W'(price_slice(PRICES_EXT, CREDIT_W, int'(sel_idx)));

    // Timer runs only while waiting for a selection; any token or button restarts it.
    assign timer_enable = (state == ST_CREDIT);
    assign timer_clear  = (state != ST_CREDIT) || token_in || (|button);

    vend_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        sel_nxt    = sel_idx;
        ps_nxt     = product_select;
        disp_nxt   = dispense;
        cv_nxt     = 1'b0;
        ct_nxt     = '0;
        rej_nxt    = 1'b0;
        ins_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (token_in) begin
                    credit_nxt = CREDIT_W'(1);
                    state_nxt  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (token_in) begin
                    if (credit < MAX_C) credit_nxt = credit + CREDIT_W'(1);
                    else                rej_nxt    = 1'b1;
                end else if (cancel) begin
                    cv_nxt     = 1'b1;
                    ct_nxt     = credit;
                    credit_nxt = '0;
                    state_nxt  = ST_IDLE;
                end else if (|button) begin
                    if (btn_price <= credit) begin
                        sel_nxt   = btn_idx;
                        ps_nxt    = btn_idx + 3'd1;
                        disp_nxt  = 1'b1;
                        state_nxt = ST_DISPENSE;
                    end else begin
                        ins_nxt = 1'b1;
                    end
                end else if (timer_expired) begin
                    cv_nxt     = 1'b1;
                    ct_nxt     = credit;
                    credit_nxt = '0;
                    state_nxt  = ST_IDLE;
                end
            end
            ST_DISPENSE: begin
                rej_nxt = token_in;
                if (dispense_done) begin
                    disp_nxt   = 1'b0;
                    credit_nxt = credit - sel_price;
                    state_nxt  = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                rej_nxt = token_in;
                if (credit != '0) begin
                    cv_nxt = 1'b1;
                    ct_nxt = credit;
                end
                credit_nxt = '0;
                ps_nxt     = 3'd0;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt  = ST_IDLE;
                credit_nxt = '0;
                ps_nxt     = 3'd0;
                disp_nxt   = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt == ST_DISPENSE) || (state_nxt == ST_CHANGE);
    end

    // State and all outputs registered; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            sel_idx        <= 3'd0;
            credit         <= '0;
            product_select <= 3'd0;
            dispense       <= 1'b0;
            change_valid   <= 1'b0;
            change_tokens  <= '0;
            token_reject   <= 1'b0;
            insufficient   <= 1'b0;
            vend_busy      <= 1'b0;
        end else begin
            state          <= state_nxt;
            sel_idx        <= sel_nxt;
            credit         <= credit_nxt;
            product_select <= ps_nxt;
            dispense       <= disp_nxt;
            change_valid   <= cv_nxt;
            change_tokens  <= ct_nxt;
            token_reject   <= rej_nxt;
            insufficient   <= ins_nxt;
            vend_busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vend_multi.sv
// Directed bench for vend_multi with a change-return scoreboard.
module tb_vend_multi;

    localparam int N  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          token_in = 1'b0;
    logic [N-1:0]  button = '0;
    logic          cancel = 1'b0;
    logic          dispense_done = 1'b0;
    logic          vend_busy, dispense, change_valid, token_reject, insufficient;
    logic [2:0]    product_select;
    logic [CW-1:0] credit, change_tokens;

    int checks = 0;
    int failures = 0;
    logic [CW-1:0] sb[$];

    vend_multi #(
        .N_PRODUCTS(N), .CREDIT_W(CW), .MAX_CREDIT(15),
        .PRICES({8'd3, 8'd2, 8'd1}), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .token_in(token_in), .button(button),
        .cancel(cancel), .dispense_done(dispense_done), .vend_busy(vend_busy),
        .dispense(dispense), .product_select(product_select), .credit(credit),
        .change_valid(change_valid), .change_tokens(change_tokens),
        .token_reject(token_reject), .insufficient(insufficient)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every change_valid pulse must match the oldest expected refund.
    always @(negedge clk) begin
        if (reset_n && change_valid) begin
            check("sb_expected_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("sb_change_tokens", 32'(change_tokens), 32'(sb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_token();
        token_in = 1'b1;
        tick();
        token_in = 1'b0;
    endtask

    task automatic press(input logic [N-1:0] b);
        button = b;
        tick();
        button = '0;
    endtask

    task automatic finish_vend(input logic [CW-1:0] exp_change);
        if (exp_change != '0) sb.push_back(exp_change);
        dispense_done = 1'b1;
        tick();
        dispense_done = 1'b0;
        check("done_dispense_low", 32'(dispense), 32'd0);
        check("done_change_early", 32'(change_valid), 32'd0);
        tick();
        check("done_change_valid", 32'(change_valid), 32'(exp_change != '0));
        check("done_busy_low", 32'(vend_busy), 32'd0);
        check("done_credit_zero", 32'(credit), 32'd0);
        check("done_select_zero", 32'(product_select), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(vend_busy), 32'd0);
        check("rst_dispense", 32'(dispense), 32'd0);
        check("rst_select", 32'(product_select), 32'd0);
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_change_valid", 32'(change_valid), 32'd0);
        check("rst_reject", 32'(token_reject), 32'd0);
        check("rst_insufficient", 32'(insufficient), 32'd0);
        reset_n = 1'b1;
        tick();

        // Exact price: product 1 costs 2
        pulse_token();
        pulse_token();
        check("exact_credit", 32'(credit), 32'd2);
        press(3'b010);
        check("exact_dispense", 32'(dispense), 32'd1);
        check("exact_select", 32'(product_select), 32'd2);
        check("exact_busy", 32'(vend_busy), 32'd1);
        finish_vend(8'd0);

        // Change return: 3 tokens, product 0 costs 1
        repeat (3) pulse_token();
        press(3'b001);
        check("change_select", 32'(product_select), 32'd1);
        finish_vend(8'd2);

        // Insufficient then top-up
        pulse_token();
        press(3'b100);
        check("insuf_pulse", 32'(insufficient), 32'd1);
        check("insuf_credit", 32'(credit), 32'd1);
        check("insuf_no_dispense", 32'(dispense), 32'd0);
        tick();
        check("insuf_one_cycle", 32'(insufficient), 32'd0);
        pulse_token();
        pulse_token();
        press(3'b100);
        check("insuf_retry_select", 32'(product_select), 32'd3);
        pulse_token();
        check("disp_token_reject", 32'(token_reject), 32'd1);
        check("disp_credit_kept", 32'(credit), 32'd3);
        check("disp_still_high", 32'(dispense), 32'd1);
        finish_vend(8'd0);

        // Saturation: 16 tokens, the last is rejected
        for (int i = 0; i < 15; i++) begin
            pulse_token();
            check("sat_no_reject", 32'(token_reject), 32'd0);
        end
        pulse_token();
        check("sat_reject", 32'(token_reject), 32'd1);
        check("sat_credit", 32'(credit), 32'd15);
        tick();
        check("sat_reject_one_cycle", 32'(token_reject), 32'd0);
        press(3'b001);
        finish_vend(8'd14);

        // Cancel refund
        pulse_token();
        pulse_token();
        sb.push_back(8'd2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_valid", 32'(change_valid), 32'd1);
        check("cancel_credit", 32'(credit), 32'd0);
        check("cancel_busy", 32'(vend_busy), 32'd0);

        // Timeout refund after 10 idle cycles in CREDIT
        pulse_token();
        for (int i = 0; i < 9; i++) begin
            tick();
            check("tmo_not_yet", 32'(change_valid), 32'd0);
        end
        check("tmo_credit_held", 32'(credit), 32'd1);
        sb.push_back(8'd1);
        tick();
        check("tmo_valid", 32'(change_valid), 32'd1);
        check("tmo_credit", 32'(credit), 32'd0);
        tick();

        // Simultaneous buttons: lowest index wins; then reset mid-dispense
        repeat (3) pulse_token();
        press(3'b110);
        check("simul_select", 32'(product_select), 32'd2);
        check("simul_dispense", 32'(dispense), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_dispense", 32'(dispense), 32'd0);
        check("rstmid_select", 32'(product_select), 32'd0);
        check("rstmid_busy", 32'(vend_busy), 32'd0);
        check("rstmid_credit", 32'(credit), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_multi.md
Name: vend_multi

Overview:
- Parametrised token vending controller that generalises the single-machine coffee vend FSM.
- Supports N products with per-product token prices, saturating credit, a cancel/refund button and an inactivity timeout refund.
- Uses a dispense/done handshake to the dispenser mechanism and returns change as a one-cycle valid pulse.
- Sits between the front-panel inputs (token slot, buttons) and the dispenser/change-hopper logic.

Parameters:
N_PRODUCTS, 3, number of selectable products (1..7)
CREDIT_W, 8, width of credit and change counters
MAX_CREDIT, 15, credit ceiling in tokens; tokens beyond it are rejected
PRICES, {8'd3,8'd2,8'd1}, packed N_PRODUCTS*CREDIT_W vector; slice i is the price of product i (product 0 = LSB slice)
TIMEOUT_CYCLES, 1000, idle cycles in CREDIT before automatic refund (0 disables)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
token_in  input  1  one token inserted this cycle (single-cycle pulse)
button  input  N_PRODUCTS  product select buttons, bit i = product i
cancel  input  1  refund request
dispense_done  input  1  dispenser finished (pulse)
vend_busy  output  1  high in DISPENSE and CHANGE states
dispense  output  1  held high until dispense_done
product_select  output  3  0 = none, i+1 = product i, held during DISPENSE
credit  output  CREDIT_W  current credit, for display
change_valid  output  1  one-cycle pulse qualifying change_tokens
change_tokens  output  CREDIT_W  tokens to return, valid only with change_valid
token_reject  output  1  one-cycle pulse: token returned unaccepted
insufficient  output  1  one-cycle pulse: selected product price > credit

Behaviour:
- Reset: asynchronous on reset_n low. State IDLE; all outputs 0; credit 0; timer 0. Reset mid-dispense drops dispense immediately; credit is lost by design.
- Registered outputs: every output is registered. Pulses last exactly one cycle, asserted the cycle after the triggering input is sampled.
- States: IDLE, CREDIT, DISPENSE, CHANGE (encoding in package).
- IDLE:
  - token_in: credit <= 1, go to CREDIT.
  - button, cancel and dispense_done are ignored.
- CREDIT, in priority order:
  - token_in: if credit < MAX_CREDIT, credit += 1; otherwise token_reject pulse and credit unchanged. Buttons are ignored that cycle. Timer cleared.
  - cancel: change_valid with change_tokens = credit; credit <= 0; go to IDLE.
  - Any button: lowest set index i wins. If PRICES[i] <= credit, latch i, product_select <= i+1, dispense <= 1, go to DISPENSE. Otherwise insufficient pulse and remain in CREDIT. Timer cleared.
  - Timeout: when the timer reaches TIMEOUT_CYCLES-1 with no token or button, refund exactly as cancel.
  - dispense_done is ignored.
- DISPENSE:
  - dispense held at 1.
  - token_in: token_reject pulse.
  - button and cancel are ignored.
  - dispense_done: dispense <= 0, credit <= credit - PRICES[i], go to CHANGE.
- CHANGE (one cycle):
  - If credit != 0, change_valid pulse with change_tokens = credit.
  - credit <= 0, product_select <= 0, go to IDLE.
  - token_in in this cycle: token_reject pulse.
- Latency:
  - button to dispense high: 1 cycle.
  - dispense_done to change_valid: 2 cycles.
  - cancel to change_valid: 1 cycle.
- Arithmetic:
  - Subtraction never underflows, because the price was checked against credit on entry.
  - Credit saturates at MAX_CREDIT.
  - Elaboration fails if any price is 0 or exceeds MAX_CREDIT, or if MAX_CREDIT >= 2^CREDIT_W.
- vend_busy = state is DISPENSE or CHANGE.

Decomposition:
- vend_pkg holds:
  - the state enum/localparams (IDLE=0, CREDIT=1, DISPENSE=2, CHANGE=3);
  - a function that extracts price slice i from PRICES;
  - a lowest-set-bit priority encoder function.
- Sub-module vend_timer holds the idle counter. Its inputs are clk, reset_n, clear, enable; its output is expired. It is tied to TIMEOUT_CYCLES and has a constant-0 expired when TIMEOUT_CYCLES = 0.

Test Plan:
- Exact price: 2 tokens, button[1] (price 2) -> dispense=1, product_select=2. dispense_done -> credit 0, no change_valid, IDLE.
- Change return: 3 tokens, button[0] (price 1), dispense_done -> change_valid with change_tokens=2 two cycles after done.
- Insufficient: 1 token, button[2] (price 3) -> insufficient pulse, credit stays 1. Then 2 tokens and button[2] -> dispense with product_select=3.
- Saturation/reject: 16 tokens with MAX_CREDIT=15 -> credit=15, one token_reject pulse. A token during DISPENSE -> token_reject, credit unchanged.
- Cancel/timeout: 2 tokens, cancel -> change_tokens=2, IDLE. With TIMEOUT_CYCLES=10, 1 token then 10 idle cycles -> change_tokens=1.
- Simultaneous/reset: button=3'b110 with credit 3 -> product 1 chosen. reset_n low mid-DISPENSE -> all outputs 0 immediately.
